uart_tx_feeder: RTL and testbench
=================================

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Purpose: byte FIFO plus handshake sequencer that drives the parallel side of the team's UART transmitter (data, ena rising-edge start, sent done flag).

Interface
- Parameters
  - REQ-001 The block SHALL have parameter DEPTH, default 16, meaning FIFO entries (power of two, 2..256).
  - REQ-002 The block SHALL have parameter TIMEOUT, default 8, meaning cycles tx_ena may stay high without a start acknowledge.
- Ports
  - REQ-003 The block SHALL have one clock; reset is asynchronous and active-high (ports clk and rst).
  - REQ-004 The block SHALL have port clk, input, 1, rising-edge clock.
  - REQ-005 The block SHALL have port rst, input, 1, asynchronous active-high reset.
  - REQ-006 The block SHALL have port wr_en, input, 1, push request.
  - REQ-007 The block SHALL have port wr_data, input, 8, byte to push.
  - REQ-008 The block SHALL have port full, output, 1, FIFO holds DEPTH bytes.
  - REQ-009 The block SHALL have port empty, output, 1, FIFO holds 0 bytes.
  - REQ-010 The block SHALL have port level, output, clog2(DEPTH)+1, occupancy.
  - REQ-011 The block SHALL have port overflow, output, 1, sticky flag for a rejected push.
  - REQ-012 The block SHALL have port tx_data, output, 8, byte presented to the transmitter.
  - REQ-013 The block SHALL have port tx_ena, output, 1, transmitter start request (rising edge starts a frame).
  - REQ-014 The block SHALL have port tx_sent, input, 1, transmitter done flag (low while sending, high when idle or done).

Function
- FIFO
  - REQ-015 A push SHALL occur on a clock edge with wr_en=1 and full=0; wr_data is written at the tail and level increments.
  - REQ-016 A push with full=1 SHALL be dropped, leave the FIFO unchanged, and set overflow=1 until reset, even if a pop occurs in the same cycle.
  - REQ-017 Pointers SHALL wrap modulo DEPTH.
  - REQ-018 A simultaneous accepted push and pop SHALL leave level unchanged.
  - REQ-019 full, empty and level SHALL be registered and update on the edge of the push or pop.
- Sequencer: states IDLE, ASSERT, WAIT_DONE, GAP; all outputs registered.
  - REQ-020 IDLE: tx_ena=0; go to ASSERT when empty=0 and tx_sent=1; on that edge load tx_data with the head byte and set tx_ena=1.
  - REQ-021 ASSERT: hold tx_ena=1 and tx_data stable.
    - If tx_sent=0 is sampled, pop the head and go to WAIT_DONE with tx_ena=0.
    - If TIMEOUT cycles elapse without tx_sent=0, go to GAP with tx_ena=0 and no pop (retry).
  - REQ-022 WAIT_DONE: tx_ena=0; go to GAP when tx_sent=1 is sampled; no cycle limit.
  - REQ-023 GAP: tx_ena=0 for exactly one cycle, then go to IDLE, so tx_ena is low for at least 2 cycles between requests and every start is a clean rising edge.
  - REQ-024 tx_data SHALL change only on entry to ASSERT.
  - REQ-025 Throughput SHALL be one byte per transmitter frame plus 3 cycles of overhead.
  - REQ-026 Pushes SHALL be accepted in every sequencer state.

Reset
- REQ-027 While rst=1, the block SHALL hold: state IDLE, FIFO empty (level=0, empty=1, full=0), overflow=0, tx_ena=0, tx_data=8'h00.
- REQ-028 Reset mid-frame SHALL discard all queued bytes and drop tx_ena immediately; the transmitter's frame in flight is not affected.
- REQ-029 After reset mid-frame, IDLE SHALL wait for tx_sent=1 before starting a new request.

Verification (bench includes a cycle model of the transmitter: frame completes 152 cycles after start)
- REQ-030 Single byte: push 8'h55 into the empty FIFO at edge 0 -> tx_ena=1 and tx_data=8'h55 after edge 1; pop on ack; serial line shows 0x55; after the frame, tx_ena low for 2 or more cycles; empty=1.
- REQ-031 Burst: push 8'h01..8'h10 (16 bytes, DEPTH=16) back-to-back -> full=1 after the 16th push; the 17th push sets overflow=1; bytes are transmitted in order 01..10; level counts down to 0.
- REQ-032 Wrap: push 10 bytes, let 8 drain, push 12 more -> all 22 bytes are transmitted in order with no loss.
- REQ-033 Timeout: transmitter model holds tx_sent=1 and ignores ena -> tx_ena is high for exactly 8 cycles, then low for at least 2 cycles, then reasserts with the same tx_data; level is unchanged.
- REQ-034 Simultaneous push and pop at level 5 -> level stays 5.
- REQ-035 Simultaneous push and pop at full -> level becomes DEPTH-1 and overflow=1.
- REQ-036 Reset in WAIT_DONE with 3 bytes queued -> tx_ena=0 and level=0 immediately; no new tx_ena until tx_sent returns to 1; the next pushed byte is sent normally.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO feeding the parallel side of a UART transmitter through an
// ena/sent handshake. An unacknowledged start request is withdrawn and retried after TIMEOUT.
module uart_tx_feeder #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               tx_data,
    output logic                     tx_ena,
    input  logic                     tx_sent
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StAssert, StWaitDone, StGap} state_e;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          overflow_q, overflow_d;
    logic          push, pop;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_ena_q, tx_ena_d;

    // FIFO bookkeeping; a push while full is dropped even if a pop frees a slot this cycle.
    always_comb begin
        push       = wr_en && !full_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q || (wr_en && full_q);
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        full_d  = (level_d == LW'(DEPTH));
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            tx_data_q <= 8'h00;
            tx_ena_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            tx_data_q <= tx_data_d;
            tx_ena_q  <= tx_ena_d;
        end
    end

    // Sequencer next state; IDLE also waits out a frame still in flight after reset.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!empty_q && tx_sent) begin
                    state_d = StAssert;
                end
            end
            StAssert: begin
                if (!tx_sent) begin
                    state_d = StWaitDone;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = StGap;
                end
            end
            StWaitDone: begin
                if (tx_sent) begin
                    state_d = StGap;
                end
            end
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Sequencer outputs; tx_data is loaded only on entry to ASSERT.
    always_comb begin
        tx_ena_d  = 1'b0;
        tx_data_d = tx_data_q;
        timer_d   = '0;
        pop       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (state_d == StAssert) begin
                    tx_ena_d  = 1'b1;
                    tx_data_d = mem[rd_ptr_q];
                end
            end
            StAssert: begin
                pop      = !tx_sent;
                tx_ena_d = (state_d == StAssert);
                timer_d  = timer_q + TW'(1);
            end
            default: ;
        endcase
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign tx_data  = tx_data_q;
    assign tx_ena   = tx_ena_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: randomized bench with a cycle model of the UART transmitter and a
// queue reference of the accepted byte stream.
module tb_uart_tx_feeder;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 8;
    localparam int FRAME   = 152;

    logic                   clk     = 1'b0;
    logic                   rst     = 1'b1;
    logic                   wr_en   = 1'b0;
    logic [7:0]             wr_data = 8'h00;
    logic                   full, empty, overflow, tx_ena, tx_sent;
    logic [$clog2(DEPTH):0] level;
    logic [7:0]             tx_data;

    // 0: normal transmitter, 1: ignores ena, 2: holds busy, 3: bench drives tx_sent
    int         mode        = 0;
    logic       model_sent  = 1'b1;
    logic       manual_sent = 1'b1;
    int         busy_cnt    = 0;
    logic       ena_prev    = 1'b0;
    logic [7:0] sent_q[$];

    logic [7:0] exp_q[$];
    int         base     = 0;
    int         man_pops = 0;
    logic       ref_ovf  = 1'b0;
    int         n_checks = 0;
    int         n_pass   = 0;

    assign tx_sent = (mode == 3) ? manual_sent : model_sent;

    uart_tx_feeder #(
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .overflow(overflow),
        .tx_data (tx_data),
        .tx_ena  (tx_ena),
        .tx_sent (tx_sent)
    );

    always #5 clk = ~clk;

    // Transmitter: a rising ena starts a frame that ends FRAME cycles later.
    initial begin
        forever begin
            @(negedge clk);
            if (mode == 2) begin
                model_sent = 1'b0;
                busy_cnt   = 0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) model_sent = 1'b1;
            end else if (mode == 0 && tx_ena === 1'b1 && ena_prev == 1'b0) begin
                sent_q.push_back(tx_data);
                model_sent = 1'b0;
                busy_cnt   = FRAME;
            end else begin
                model_sent = 1'b1;
            end
            ena_prev = tx_ena;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got no summary want summary");
        $fatal(1);
    end

    function automatic int occupancy();
        return exp_q.size() - (sent_q.size() - base) - man_pops;
    endfunction

    task automatic ref_push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        if (occupancy() < DEPTH) exp_q.push_back(b);
        else ref_ovf = 1'b1;
    endtask

    task automatic push_one(input logic [7:0] b);
        ref_push(b);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic start_test(input int m);
        int i;
        for (i = 0; i < FRAME + 20 && busy_cnt != 0; i++) @(negedge clk);
        if (busy_cnt != 0) begin
            n_checks++;
            $display("FAIL settle: transmitter busy count got %0d want 0", busy_cnt);
        end
        mode        = m;
        manual_sent = 1'b1;
        wr_en       = 1'b0;
        rst         = 1'b1;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        base     = sent_q.size();
        man_pops = 0;
        ref_ovf  = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_drain(input int budget, output bit done);
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sent_q.size() - base == exp_q.size() && busy_cnt == 0) begin
                done = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (level !== 0) $display("FAIL rst_level: got %0d want 0", level); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL rst_empty: got %b want 1", empty); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL rst_full: got %b want 0", full); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL rst_ovf: got %b want 0", overflow); else n_pass++;
        n_checks++; if (tx_ena !== 1'b0) $display("FAIL rst_ena: got %b want 0", tx_ena); else n_pass++;
        n_checks++; if (tx_data !== 8'h00) $display("FAIL rst_data: got %h want 00", tx_data); else n_pass++;
    endtask

    task automatic test_single();
        bit done;
        int low;
        start_test(0);
        push_one(8'h55);
        n_checks++; if (level !== occupancy()) $display("FAIL single_level: got %0d want %0d", level, occupancy()); else n_pass++;
        @(negedge clk);
        n_checks++; if (tx_ena !== 1'b1) $display("FAIL single_ena: got %b want 1", tx_ena); else n_pass++;
        n_checks++; if (tx_data !== 8'h55) $display("FAIL single_data: got %h want 55", tx_data); else n_pass++;
        wait_drain(FRAME + 50, done);
        n_checks++; if (!done) $display("FAIL single_done: got timeout want frame end"); else n_pass++;
        low = 0;
        repeat (4) begin
            if (tx_ena === 1'b0) low++;
            @(negedge clk);
        end
        n_checks++; if (low != 4) $display("FAIL single_gap: got %0d low cycles want 4", low); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL single_empty: got %b want 1", empty); else n_pass++;
        n_checks++;
        if (sent_q.size() <= base) $display("FAIL single_sent: got no byte want %h", exp_q[0]);
        else if (sent_q[base] !== exp_q[0]) $display("FAIL single_sent: got %h want %h", sent_q[base], exp_q[0]);
        else n_pass++;
    endtask

    task automatic check_order(input string name);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (sent_q.size() <= base + i)
                $display("FAIL %s_byte%0d: got nothing want %h", name, i, exp_q[i]);
            else if (sent_q[base + i] !== exp_q[i])
                $display("FAIL %s_byte%0d: got %h want %h", name, i, sent_q[base + i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_burst();
        bit done;
        int viol;
        logic [$clog2(DEPTH):0] prev;
        start_test(2);
        for (int i = 1; i <= DEPTH; i++) push_one(8'(i));
        n_checks++; if (full !== (occupancy() == DEPTH)) $display("FAIL burst_full: got %b want %b", full, occupancy() == DEPTH); else n_pass++;
        n_checks++; if (level !== occupancy()) $display("FAIL burst_level: got %0d want %0d", level, occupancy()); else n_pass++;
        push_one(8'h11);
        n_checks++; if (overflow !== ref_ovf) $display("FAIL burst_ovf: got %b want %b", overflow, ref_ovf); else n_pass++;
        n_checks++; if (level !== occupancy()) $display("FAIL burst_level17: got %0d want %0d", level, occupancy()); else n_pass++;
        mode = 0;
        prev = level;
        viol = 0;
        done = 1'b0;
        for (int i = 0; i < DEPTH * (FRAME + 10) + 100; i++) begin
            @(negedge clk);
            if (level > prev) viol++;
            prev = level;
            if (sent_q.size() - base == exp_q.size() && busy_cnt == 0) begin
                done = 1'b1;
                break;
            end
        end
        n_checks++; if (!done) $display("FAIL burst_done: got %0d sent want %0d", sent_q.size() - base, exp_q.size()); else n_pass++;
        n_checks++; if (viol != 0) $display("FAIL burst_countdown: got %0d increases want 0", viol); else n_pass++;
        n_checks++; if (level !== 0) $display("FAIL burst_drained: got %0d want 0", level); else n_pass++;
        check_order("burst");
    endtask

    task automatic test_wrap();
        bit done;
        start_test(0);
        for (int i = 0; i < 10; i++) push_one(8'($urandom_range(255)));
        done = 1'b0;
        for (int i = 0; i < 8 * (FRAME + 10) + 50; i++) begin
            @(negedge clk);
            if (sent_q.size() - base >= 8) begin
                done = 1'b1;
                break;
            end
        end
        n_checks++; if (!done) $display("FAIL wrap_first: got %0d sent want 8", sent_q.size() - base); else n_pass++;
        for (int i = 0; i < 12; i++) push_one(8'($urandom_range(255)));
        wait_drain(16 * (FRAME + 10), done);
        n_checks++; if (!done) $display("FAIL wrap_done: got %0d sent want %0d", sent_q.size() - base, exp_q.size()); else n_pass++;
        n_checks++; if (overflow !== ref_ovf) $display("FAIL wrap_ovf: got %b want %b", overflow, ref_ovf); else n_pass++;
        n_checks++; if (level !== occupancy()) $display("FAIL wrap_level: got %0d want %0d", level, occupancy()); else n_pass++;
        check_order("wrap");
    endtask

    task automatic test_timeout();
        logic [7:0] b;
        int hi, lo;
        start_test(1);
        b = 8'($urandom_range(255));
        push_one(b);
        for (int i = 0; i < 5 && tx_ena !== 1'b1; i++) @(negedge clk);
        hi = 0;
        while (tx_ena === 1'b1 && hi < 4 * TIMEOUT) begin
            hi++;
            @(negedge clk);
        end
        n_checks++; if (hi != TIMEOUT) $display("FAIL timeout_high: got %0d cycles want %0d", hi, TIMEOUT); else n_pass++;
        lo = 0;
        while (tx_ena !== 1'b1 && lo < 4 * TIMEOUT) begin
            lo++;
            @(negedge clk);
        end
        n_checks++; if (lo < 2 || lo >= 4 * TIMEOUT) $display("FAIL timeout_gap: got %0d low cycles want 2..%0d", lo, 4 * TIMEOUT - 1); else n_pass++;
        n_checks++; if (tx_data !== b) $display("FAIL timeout_data: got %h want %h", tx_data, b); else n_pass++;
        n_checks++; if (level !== occupancy()) $display("FAIL timeout_level: got %0d want %0d", level, occupancy()); else n_pass++;
    endtask

    task automatic test_simul_pop();
        start_test(3);
        for (int i = 0; i < 5; i++) push_one(8'($urandom_range(255)));
        n_checks++; if (level !== occupancy()) $display("FAIL simul_level_pre: got %0d want %0d", level, occupancy()); else n_pass++;
        n_checks++; if (tx_ena !== 1'b1) $display("FAIL simul_ena: got %b want 1", tx_ena); else n_pass++;
        manual_sent = 1'b0;
        ref_push(8'($urandom_range(255)));
        man_pops++;
        @(negedge clk);
        wr_en       = 1'b0;
        manual_sent = 1'b1;
        n_checks++; if (level !== occupancy()) $display("FAIL simul_level: got %0d want %0d", level, occupancy()); else n_pass++;
        n_checks++; if (tx_ena !== 1'b0) $display("FAIL simul_ack: got %b want 0", tx_ena); else n_pass++;
    endtask

    task automatic test_full_pop();
        start_test(3);
        manual_sent = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_one(8'($urandom_range(255)));
        n_checks++; if (full !== 1'b1) $display("FAIL fullpop_full: got %b want 1", full); else n_pass++;
        manual_sent = 1'b1;
        @(negedge clk);
        n_checks++; if (tx_ena !== 1'b1) $display("FAIL fullpop_ena: got %b want 1", tx_ena); else n_pass++;
        manual_sent = 1'b0;
        ref_push(8'($urandom_range(255)));
        man_pops++;
        @(negedge clk);
        wr_en = 1'b0;
        n_checks++; if (level !== occupancy()) $display("FAIL fullpop_level: got %0d want %0d", level, occupancy()); else n_pass++;
        n_checks++; if (overflow !== ref_ovf) $display("FAIL fullpop_ovf: got %b want %b", overflow, ref_ovf); else n_pass++;
        n_checks++; if (full !== (occupancy() == DEPTH)) $display("FAIL fullpop_notfull: got %b want %b", full, occupancy() == DEPTH); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        int viol;
        bit done;
        start_test(0);
        for (int i = 0; i < 4; i++) push_one(8'($urandom_range(255)));
        repeat (3) @(negedge clk);
        n_checks++; if (level !== occupancy()) $display("FAIL midrst_level_pre: got %0d want %0d", level, occupancy()); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (tx_ena !== 1'b0) $display("FAIL midrst_ena: got %b want 0", tx_ena); else n_pass++;
        n_checks++; if (level !== 0) $display("FAIL midrst_level: got %0d want 0", level); else n_pass++;
        exp_q.delete();
        base = sent_q.size();
        @(negedge clk);
        rst = 1'b0;
        b = 8'($urandom_range(255));
        push_one(b);
        viol = 0;
        done = 1'b0;
        for (int i = 0; i < FRAME + 20; i++) begin
            if (busy_cnt == 0) begin
                done = 1'b1;
                break;
            end
            if (tx_ena !== 1'b0) viol++;
            @(negedge clk);
        end
        n_checks++; if (viol != 0 || !done) $display("FAIL midrst_hold: got %0d early ena cycles want 0", viol); else n_pass++;
        wait_drain(FRAME + 50, done);
        n_checks++; if (!done) $display("FAIL midrst_done: got %0d sent want 1", sent_q.size() - base); else n_pass++;
        check_order("midrst");
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_wrap();
        test_timeout();
        test_simul_pop();
        test_full_pop();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
